pc_ctrl: RTL and testbench

//  Next-PC sequencer for the fetch stage; drives pc_enable/pc_in of the PC register.

---
 rtl/pc_ctrl_if.sv | 30 +++
 rtl/pc_ctrl.sv | 155 +++++++++++++++
 tb/tb_pc_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_ctrl_if.sv
// rtl/pc_ctrl_if.sv - fetch-stage next-PC sequencer bus between pipeline (master) and pc_ctrl (slave)
interface pc_ctrl_if;
  logic [31:0] pc_cur_i;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        trap_i;
  logic [31:0] trap_vec_i;
  logic        halt_req_i;
  logic        resume_i;
  logic        step_i;
  logic        pc_enable;
  logic [31:0] pc_next;
  logic        flush_o;
  logic        misalign_o;
  logic        halted_o;
  logic [15:0] redir_cnt_o;

  modport master (
    output pc_cur_i, stall_i, br_taken_i, br_target_i, trap_i, trap_vec_i,
           halt_req_i, resume_i, step_i,
    input  pc_enable, pc_next, flush_o, misalign_o, halted_o, redir_cnt_o
  );

  modport slave (
    input  pc_cur_i, stall_i, br_taken_i, br_target_i, trap_i, trap_vec_i,
           halt_req_i, resume_i, step_i,
    output pc_enable, pc_next, flush_o, misalign_o, halted_o, redir_cnt_o
  );
endinterface

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - next-PC sequencer: boot, PC+4, branch/trap redirect, stall/halt hold
// Optional single-step in HALTED enabled by defining PC_CTRL_STEP_EN.
module pc_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          BOOT_WAIT    = 4
) (
  input logic       clk,
  input logic       rst,
  pc_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_HALTED
  } state_t;

  localparam logic [3:0] BOOT_WAIT_C = 4'(BOOT_WAIT);

  state_t      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pend_q, pend_d;
  logic [15:0] redir_cnt_q;
  logic        halted_q;

  logic        take_tgt;
  logic [31:0] tgt;
  logic [31:0] seq_pc;
  logic        step_req;

  assign seq_pc = bus.pc_cur_i + 32'd4;

`ifdef PC_CTRL_STEP_EN
  assign step_req = bus.step_i;
`else
  logic unused_step;
  assign unused_step = bus.step_i;
  assign step_req    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    pend_d        = pend_q;
    take_tgt      = 1'b0;
    tgt           = 32'h0;
    bus.pc_enable = 1'b0;
    bus.pc_next   = seq_pc;
    bus.flush_o   = 1'b0;
    bus.misalign_o = 1'b0;

    case (state_q)
      ST_BOOT: begin
        bus.pc_next = RESET_VECTOR;
        if (boot_cnt_q == BOOT_WAIT_C) begin
          bus.pc_enable = 1'b1;
          state_d       = ST_RUN;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      ST_RUN: begin
        if (bus.trap_i) begin
          take_tgt = 1'b1;
          tgt      = bus.trap_vec_i;
        end else if (bus.br_taken_i) begin
          if (!bus.stall_i) begin
            take_tgt = 1'b1;
            tgt      = bus.br_target_i;
          end else begin
            pend_d  = bus.br_target_i;
            state_d = ST_HOLD;
          end
        end else if (bus.halt_req_i) begin
          state_d = ST_HALTED;
        end else if (!bus.stall_i) begin
          bus.pc_enable = 1'b1;
        end
      end

      ST_HOLD: begin
        // Halt is not honoured here; the buffered redirect must land first.
        if (bus.trap_i) begin
          take_tgt = 1'b1;
          tgt      = bus.trap_vec_i;
          pend_d   = 32'h0;
          state_d  = ST_RUN;
        end else if (bus.stall_i) begin
          if (bus.br_taken_i) begin
            pend_d = bus.br_target_i;
          end
        end else begin
          take_tgt = 1'b1;
          // A redirect arriving on the release cycle is newer than the buffered one.
          tgt      = bus.br_taken_i ? bus.br_target_i : pend_q;
          state_d  = ST_RUN;
        end
      end

      ST_HALTED: begin
        if (bus.trap_i) begin
          take_tgt = 1'b1;
          tgt      = bus.trap_vec_i;
          state_d  = ST_RUN;
        end else if (bus.resume_i) begin
          state_d = ST_RUN;
        end else if (step_req) begin
          bus.pc_enable = 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (take_tgt) begin
      bus.pc_enable  = 1'b1;
      bus.pc_next    = {tgt[31:2], 2'b00};
      bus.flush_o    = 1'b1;
      bus.misalign_o = |tgt[1:0];
    end

    if (rst) begin
      bus.pc_enable  = 1'b0;
      bus.pc_next    = RESET_VECTOR;
      bus.flush_o    = 1'b0;
      bus.misalign_o = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 4'd0;
      pend_q      <= 32'h0;
      redir_cnt_q <= 16'h0;
      halted_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pend_q     <= pend_d;
      halted_q   <= (state_d == ST_HALTED);
      if (bus.flush_o && (redir_cnt_q != 16'hFFFF)) begin
        redir_cnt_q <= redir_cnt_q + 16'd1;
      end
    end
  end

  assign bus.halted_o    = halted_q;
  assign bus.redir_cnt_o = redir_cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - directed vector bench for pc_ctrl with an external PC register model
module tb_pc_ctrl;

  logic clk;
  logic rst;
  logic [31:0] pc_q;
  int checks;
  int errors;

  pc_ctrl_if bus ();

  pc_ctrl #(.RESET_VECTOR(32'h100), .BOOT_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 32'h0;
    else if (bus.pc_enable) pc_q <= bus.pc_next;
  end
  assign bus.pc_cur_i = pc_q;

  typedef struct {
    logic        st;
    logic        br;
    logic [31:0] tgt;
    logic        tr;
    logic [31:0] tv;
    logic        hr;
    logic        rs;
    logic        sp;
    logic        en;
    logic [31:0] nx;
    logic        fl;
    logic        mi;
    logic        hd;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic st, br, input logic [31:0] tgt,
                              input logic tr, input logic [31:0] tv,
                              input logic hr, rs, sp, en, input logic [31:0] nx,
                              input logic fl, mi, hd, input logic [15:0] cnt);
    vec_t v;
    v.st = st; v.br = br; v.tgt = tgt; v.tr = tr; v.tv = tv;
    v.hr = hr; v.rs = rs; v.sp = sp; v.en = en; v.nx = nx;
    v.fl = fl; v.mi = mi; v.hd = hd; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic st, br, input logic [31:0] tgt, input logic tr,
                       input logic [31:0] tv, input logic hr, rs, sp);
    bus.stall_i = st; bus.br_taken_i = br; bus.br_target_i = tgt;
    bus.trap_i = tr; bus.trap_vec_i = tv;
    bus.halt_req_i = hr; bus.resume_i = rs; bus.step_i = sp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] X = 32'h0;
`ifdef PC_CTRL_STEP_EN
  localparam logic [31:0] PC_AFTER_HALT = 32'h8;
`else
  localparam logic [31:0] PC_AFTER_HALT = 32'h4;
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(0, 0, X, 0, X, 0, 0, 0);

    //         st br tgt           tr tv      hr rs sp en nx            fl mi hd cnt
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 0,32'h100,      0,0,0,0));  // 0 boot
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 0,32'h100,      0,0,0,0));
    tbl.push_back(mk(1,1,32'h40,       1,32'h50,  1,0,0, 0,32'h100,      0,0,0,0));  // inputs ignored in boot
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 0,32'h100,      0,0,0,0));
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h100,      0,0,0,0));  // 4 first load
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h104,      0,0,0,0));
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h108,      0,0,0,0));
    tbl.push_back(mk(0,1,32'h200,      0,X,       0,0,0, 1,32'h200,      1,0,0,0));
    tbl.push_back(mk(0,1,32'h400,      0,X,       0,0,0, 1,32'h400,      1,0,0,1));  // 8
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h404,      0,0,0,2));
    tbl.push_back(mk(1,1,32'h800,      0,X,       0,0,0, 0,X,            0,0,0,2));  // 10 -> hold
    tbl.push_back(mk(1,1,32'h900,      0,X,       0,0,0, 0,X,            0,0,0,2));
    tbl.push_back(mk(1,0,X,            0,X,       0,0,0, 0,X,            0,0,0,2));
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h900,      1,0,0,2));
    tbl.push_back(mk(1,1,32'h800,      0,X,       0,0,0, 0,X,            0,0,0,3));  // 14
    tbl.push_back(mk(1,0,X,            1,32'h1C,  0,0,0, 1,32'h1C,       1,0,0,3));
    tbl.push_back(mk(1,0,X,            0,X,       0,0,0, 0,X,            0,0,0,4));
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h20,       0,0,0,4));
    tbl.push_back(mk(0,1,32'h403,      0,X,       0,0,0, 1,32'h400,      1,1,0,4));  // 18 misalign
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h404,      0,0,0,5));
    tbl.push_back(mk(0,1,32'hFFFF_FFFF,0,X,       0,0,0, 1,32'hFFFF_FFFC,1,1,0,5));
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h0,        0,0,0,6));  // wrap
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h4,        0,0,0,6));
    tbl.push_back(mk(0,0,X,            0,X,       1,0,0, 0,X,            0,0,0,6));  // 23 halt
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 0,X,            0,0,1,6));
`ifdef PC_CTRL_STEP_EN
    tbl.push_back(mk(0,0,X,            0,X,       0,0,1, 1,32'h8,        0,0,1,6));
`else
    tbl.push_back(mk(0,0,X,            0,X,       0,0,1, 0,X,            0,0,1,6));
`endif
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 0,X,            0,0,1,6));
    tbl.push_back(mk(0,1,32'h500,      0,X,       0,0,0, 0,X,            0,0,1,6));  // br ignored
    tbl.push_back(mk(0,0,X,            0,X,       1,1,0, 0,X,            0,0,1,6));  // 28 resume wins
    tbl.push_back(mk(0,0,X,            0,X,       1,0,0, 0,X,            0,0,0,6));  // re-halt
    tbl.push_back(mk(0,0,X,            0,X,       0,1,0, 0,X,            0,0,1,6));
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,PC_AFTER_HALT+32'd4, 0,0,0,6));
    tbl.push_back(mk(0,0,X,            1,32'h1C,  1,0,0, 1,32'h1C,       1,0,0,6));  // 32 trap > halt
    tbl.push_back(mk(0,0,X,            0,X,       1,0,0, 0,X,            0,0,0,7));
    tbl.push_back(mk(0,0,X,            1,32'h40,  0,0,0, 1,32'h40,       1,0,1,7));  // trap from halted
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h44,       0,0,0,8));
    tbl.push_back(mk(1,0,X,            0,X,       0,0,0, 0,X,            0,0,0,8));  // 36
    tbl.push_back(mk(1,0,X,            1,32'h80,  0,0,0, 1,32'h80,       1,0,0,8));
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'h84,       0,0,0,9));
    tbl.push_back(mk(1,1,32'hA00,      0,X,       0,0,0, 0,X,            0,0,0,9));  // 39 -> hold
    tbl.push_back(mk(1,0,X,            0,X,       1,0,0, 0,X,            0,0,0,9));
    tbl.push_back(mk(0,0,X,            0,X,       1,0,0, 1,32'hA00,      1,0,0,9));  // halt deferred
    tbl.push_back(mk(0,0,X,            0,X,       1,0,0, 0,X,            0,0,0,10));
    tbl.push_back(mk(0,0,X,            0,X,       0,1,0, 0,X,            0,0,1,10));
    tbl.push_back(mk(0,0,X,            0,X,       0,0,0, 1,32'hA04,      0,0,0,10));

    tick();
    tick();
    chk("rst_pc_enable", -1, 32'(bus.pc_enable), 32'h0);
    chk("rst_pc_next",   -1, bus.pc_next, 32'h100);
    chk("rst_flush",     -1, 32'(bus.flush_o), 32'h0);
    chk("rst_misalign",  -1, 32'(bus.misalign_o), 32'h0);
    chk("rst_halted",    -1, 32'(bus.halted_o), 32'h0);
    chk("rst_cnt",       -1, 32'(bus.redir_cnt_o), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].st, tbl[i].br, tbl[i].tgt, tbl[i].tr, tbl[i].tv,
            tbl[i].hr, tbl[i].rs, tbl[i].sp);
      #4;
      chk("pc_enable", i, 32'(bus.pc_enable), 32'(tbl[i].en));
      if (tbl[i].en) chk("pc_next", i, bus.pc_next, tbl[i].nx);
      chk("flush", i, 32'(bus.flush_o), 32'(tbl[i].fl));
      chk("misalign", i, 32'(bus.misalign_o), 32'(tbl[i].mi));
      chk("halted", i, 32'(bus.halted_o), 32'(tbl[i].hd));
      chk("redir_cnt", i, 32'(bus.redir_cnt_o), 32'(tbl[i].cnt));
      tick();
    end

    // Redirect counter saturation
    drive(0, 1, 32'h10, 0, X, 0, 0, 0);
    for (int i = 0; i < 65540; i++) tick();
    #4;
    chk("sat_cnt", 0, 32'(bus.redir_cnt_o), 32'hFFFF);
    chk("sat_flush", 0, 32'(bus.flush_o), 32'h1);
    tick();
    #4;
    chk("sat_cnt_hold", 1, 32'(bus.redir_cnt_o), 32'hFFFF);
    tick();

    // Async reset while halted
    drive(0, 0, X, 0, X, 1, 0, 0);
    tick();
    drive(0, 0, X, 0, X, 0, 0, 0);
    tick();
    chk("halt_before_rst", 0, 32'(bus.halted_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_halted", 0, 32'(bus.halted_o), 32'h0);
    chk("async_rst_cnt", 0, 32'(bus.redir_cnt_o), 32'h0);
    chk("async_rst_en", 0, 32'(bus.pc_enable), 32'h0);
    chk("async_rst_next", 0, bus.pc_next, 32'h100);
    tick();
    tick();
    rst = 1'b0;
    drive(0, 0, X, 0, X, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("reboot_en", i, 32'(bus.pc_enable), (i == 4) ? 32'h1 : 32'h0);
      chk("reboot_halted", i, 32'(bus.halted_o), 32'h0);
      if (i == 4) chk("reboot_next", i, bus.pc_next, 32'h100);
      tick();
    end
    drive(0, 0, X, 0, X, 0, 0, 0);
    #4;
    chk("reboot_seq", 0, bus.pc_next, 32'h104);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
